// File: rtl/sram_req_arbiter.sv
// sram_req_arbiter: multi-channel SRAM-like request arbiter with a grant lock
// and an in-order outstanding FIFO that steers each data_ok back to its owner.
module sram_req_arbiter #(
    parameter int NUM_CH     = 2,
    parameter int OUTS_DEPTH = 4,
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int FIXED_PRIO = 0
) (
    input  logic                              clk,
    input  logic                              resetn,
    input  logic [NUM_CH-1:0]                 m_req,
    input  logic [NUM_CH-1:0]                 m_wr,
    input  logic [2*NUM_CH-1:0]               m_size,
    input  logic [(DATA_W/8)*NUM_CH-1:0]      m_wstrb,
    input  logic [ADDR_W*NUM_CH-1:0]          m_addr,
    input  logic [DATA_W*NUM_CH-1:0]          m_wdata,
    output logic [NUM_CH-1:0]                 m_addr_ok,
    output logic [NUM_CH-1:0]                 m_data_ok,
    output logic [DATA_W-1:0]                 m_rdata,
    output logic                              s_req,
    output logic                              s_wr,
    output logic [1:0]                        s_size,
    output logic [(DATA_W/8)-1:0]             s_wstrb,
    output logic [ADDR_W-1:0]                 s_addr,
    output logic [DATA_W-1:0]                 s_wdata,
    input  logic                              s_addr_ok,
    input  logic                              s_data_ok,
    input  logic [DATA_W-1:0]                 s_rdata,
    output logic [$clog2(OUTS_DEPTH):0]       outs_cnt,
    output logic                              err_unexp
);

    localparam int SW  = DATA_W / 8;
    localparam int CW  = $clog2(OUTS_DEPTH) + 1;
    localparam int CHW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int PW  = (OUTS_DEPTH > 1) ? $clog2(OUTS_DEPTH) : 1;

    logic [CHW-1:0] r_rr_ptr;
    logic [CHW-1:0] r_lock_ch;
    logic           r_lock_v;
    logic           r_err;
    logic [CW-1:0]  r_cnt;
    logic [PW-1:0]  r_wptr;
    logic [PW-1:0]  r_rptr;
    logic [CHW-1:0] r_fifo [OUTS_DEPTH];

    logic           w_full;
    logic           w_empty;
    logic           w_gnt_v;
    logic           w_hs;
    logic           w_pop;
    logic [CHW-1:0] w_pick;
    logic [CHW-1:0] w_gnt;
    logic [CHW-1:0] w_head;

    // Scan downwards so the last hit is the first requester in priority order.
    function automatic logic [CHW-1:0] f_pick(input logic [NUM_CH-1:0] req,
                                              input logic [CHW-1:0]    ptr);
        logic [CHW-1:0] pick;
        int             k;
        pick = '0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            k = (FIXED_PRIO != 0) ? i : (int'(ptr) + i) % NUM_CH;
            if (req[k[CHW-1:0]]) pick = k[CHW-1:0];
        end
        return pick;
    endfunction

    assign w_full  = (r_cnt == CW'(OUTS_DEPTH));
    assign w_empty = (r_cnt == '0);
    assign w_pick  = f_pick(m_req, r_rr_ptr);
    assign w_gnt   = r_lock_v ? r_lock_ch : w_pick;
    assign w_gnt_v = resetn & ~w_full & (r_lock_v | (|m_req));
    assign s_req   = w_gnt_v & m_req[w_gnt];
    assign w_hs    = s_req & s_addr_ok;
    assign w_head  = r_fifo[r_rptr];
    assign w_pop   = s_data_ok & ~w_empty;

    assign m_rdata   = s_rdata;
    assign outs_cnt  = r_cnt;
    assign err_unexp = r_err;

    always_comb begin
        s_wr      = 1'b0;
        s_size    = '0;
        s_wstrb   = '0;
        s_addr    = '0;
        s_wdata   = '0;
        m_addr_ok = '0;
        m_data_ok = '0;
        if (w_gnt_v) begin
            s_wr    = m_wr[w_gnt];
            s_size  = m_size[2*w_gnt +: 2];
            s_wstrb = m_wstrb[w_gnt*SW +: SW];
            s_addr  = m_addr[w_gnt*ADDR_W +: ADDR_W];
            s_wdata = m_wdata[w_gnt*DATA_W +: DATA_W];
        end
        if (w_hs)  m_addr_ok[w_gnt]  = 1'b1;
        if (w_pop) m_data_ok[w_head] = 1'b1;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_rr_ptr  <= '0;
            r_lock_v  <= 1'b0;
            r_lock_ch <= '0;
            r_cnt     <= '0;
            r_wptr    <= '0;
            r_rptr    <= '0;
            r_err     <= 1'b0;
        end else begin
            // A full FIFO holds s_req low, so the lock simply persists across it.
            if (s_req && !s_addr_ok) begin
                r_lock_v  <= 1'b1;
                r_lock_ch <= w_gnt;
            end else if (w_hs) begin
                r_lock_v  <= 1'b0;
            end
            if (w_hs) begin
                r_rr_ptr <= (w_gnt == CHW'(NUM_CH - 1)) ? '0 : w_gnt + 1'b1;
                r_wptr   <= (r_wptr == PW'(OUTS_DEPTH - 1)) ? '0 : r_wptr + 1'b1;
            end
            if (w_pop)
                r_rptr <= (r_rptr == PW'(OUTS_DEPTH - 1)) ? '0 : r_rptr + 1'b1;
            if (w_hs && !w_pop)
                r_cnt <= r_cnt + 1'b1;
            else if (!w_hs && w_pop)
                r_cnt <= r_cnt - 1'b1;
            if (s_data_ok && w_empty)
                r_err <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (w_hs) r_fifo[r_wptr] <= w_gnt;
    end

endmodule

// File: tb/tb_sram_req_arbiter.sv
// Bench for sram_req_arbiter: directed scenarios plus a randomized run against
// a queue-based reference model of arbitration and response ordering.
module tb_sram_req_arbiter;

    localparam int N  = 2;
    localparam int D  = 4;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int SW = 4;
    localparam int FN = 4;

    logic clk = 1'b0;
    logic resetn;
    always #5 clk = ~clk;

    logic [N-1:0]    m_req, m_wr, m_addr_ok, m_data_ok;
    logic [2*N-1:0]  m_size;
    logic [SW*N-1:0] m_wstrb;
    logic [AW*N-1:0] m_addr;
    logic [DW*N-1:0] m_wdata;
    logic [DW-1:0]   m_rdata, s_rdata, s_wdata;
    logic            s_req, s_wr, s_addr_ok, s_data_ok, err_unexp;
    logic [1:0]      s_size;
    logic [SW-1:0]   s_wstrb;
    logic [AW-1:0]   s_addr;
    logic [2:0]      outs_cnt;

    logic [FN-1:0]    fp_req, fp_wr, fp_addr_ok, fp_data_ok;
    logic [2*FN-1:0]  fp_size;
    logic [SW*FN-1:0] fp_wstrb;
    logic [AW*FN-1:0] fp_addr;
    logic [DW*FN-1:0] fp_wdata;
    logic [DW-1:0]    fp_rdata, fp_s_rdata, fp_s_wdata;
    logic             fp_s_req, fp_s_wr, fp_s_addr_ok, fp_s_data_ok, fp_err;
    logic [1:0]       fp_s_size;
    logic [SW-1:0]    fp_s_wstrb;
    logic [AW-1:0]    fp_s_addr;
    logic [2:0]       fp_cnt;

    int n_checks = 0;
    int n_errors = 0;

    sram_req_arbiter #(.NUM_CH(N), .OUTS_DEPTH(D), .ADDR_W(AW), .DATA_W(DW), .FIXED_PRIO(0)) u_dut (
        .clk(clk), .resetn(resetn),
        .m_req(m_req), .m_wr(m_wr), .m_size(m_size), .m_wstrb(m_wstrb),
        .m_addr(m_addr), .m_wdata(m_wdata),
        .m_addr_ok(m_addr_ok), .m_data_ok(m_data_ok), .m_rdata(m_rdata),
        .s_req(s_req), .s_wr(s_wr), .s_size(s_size), .s_wstrb(s_wstrb),
        .s_addr(s_addr), .s_wdata(s_wdata),
        .s_addr_ok(s_addr_ok), .s_data_ok(s_data_ok), .s_rdata(s_rdata),
        .outs_cnt(outs_cnt), .err_unexp(err_unexp)
    );

    sram_req_arbiter #(.NUM_CH(FN), .OUTS_DEPTH(D), .ADDR_W(AW), .DATA_W(DW), .FIXED_PRIO(1)) u_fp (
        .clk(clk), .resetn(resetn),
        .m_req(fp_req), .m_wr(fp_wr), .m_size(fp_size), .m_wstrb(fp_wstrb),
        .m_addr(fp_addr), .m_wdata(fp_wdata),
        .m_addr_ok(fp_addr_ok), .m_data_ok(fp_data_ok), .m_rdata(fp_rdata),
        .s_req(fp_s_req), .s_wr(fp_s_wr), .s_size(fp_s_size), .s_wstrb(fp_s_wstrb),
        .s_addr(fp_s_addr), .s_wdata(fp_s_wdata),
        .s_addr_ok(fp_s_addr_ok), .s_data_ok(fp_s_data_ok), .s_rdata(fp_s_rdata),
        .outs_cnt(fp_cnt), .err_unexp(fp_err)
    );

    task automatic clear_inputs();
        m_req = '0; m_wr = '0; m_size = '0; m_wstrb = '0; m_addr = '0; m_wdata = '0;
        s_addr_ok = 1'b0; s_data_ok = 1'b0; s_rdata = '0;
        fp_req = '0; fp_wr = '0; fp_size = '0; fp_wstrb = '0; fp_addr = '0; fp_wdata = '0;
        fp_s_addr_ok = 1'b0; fp_s_data_ok = 1'b0; fp_s_rdata = '0;
    endtask

    task automatic apply_reset();
        resetn = 1'b0;
        clear_inputs();
        repeat (2) @(negedge clk);
        resetn = 1'b1;
    endtask

    task automatic test_reset();
        resetn = 1'b0;
        m_req = 2'b11; s_addr_ok = 1'b1; s_data_ok = 1'b1;
        for (int c = 0; c < 2; c++) begin
            #1;
            n_checks++; if (s_req !== 1'b0) begin n_errors++; $display("FAIL reset_s_req: got %b want 0", s_req); end
            n_checks++; if (m_addr_ok !== 2'b00) begin n_errors++; $display("FAIL reset_addr_ok: got %b want 00", m_addr_ok); end
            n_checks++; if (m_data_ok !== 2'b00) begin n_errors++; $display("FAIL reset_data_ok: got %b want 00", m_data_ok); end
            n_checks++; if (outs_cnt !== 3'd0) begin n_errors++; $display("FAIL reset_cnt: got %0d want 0", outs_cnt); end
            n_checks++; if (err_unexp !== 1'b0) begin n_errors++; $display("FAIL reset_err: got %b want 0", err_unexp); end
            @(negedge clk);
        end
        apply_reset();
    endtask

    task automatic test_contention();
        logic [N-1:0] exp_ok;
        apply_reset();
        m_req = 2'b11; s_addr_ok = 1'b1;
        for (int k = 0; k < 4; k++) begin
            #1;
            exp_ok = (k % 2 == 0) ? 2'b01 : 2'b10;
            n_checks++; if (m_addr_ok !== exp_ok) begin n_errors++; $display("FAIL contention_grant[%0d]: got %b want %b", k, m_addr_ok, exp_ok); end
            n_checks++; if (int'(outs_cnt) !== k) begin n_errors++; $display("FAIL contention_cnt[%0d]: got %0d want %0d", k, outs_cnt, k); end
            @(negedge clk);
        end
        #1;
        n_checks++; if (s_req !== 1'b0) begin n_errors++; $display("FAIL contention_full_sreq: got %b want 0", s_req); end
        n_checks++; if (outs_cnt !== 3'd4) begin n_errors++; $display("FAIL contention_full_cnt: got %0d want 4", outs_cnt); end
        @(negedge clk);
        clear_inputs();
    endtask

    task automatic test_lock();
        apply_reset();
        m_req = 2'b10; m_addr[63:32] = 32'h100; m_addr[31:0] = 32'h200;
        #1;
        n_checks++; if (s_addr !== 32'h100) begin n_errors++; $display("FAIL lock_addr_c0: got %h want 100", s_addr); end
        @(negedge clk);
        m_req = 2'b11;
        for (int c = 1; c < 3; c++) begin
            #1;
            n_checks++; if (s_addr !== 32'h100) begin n_errors++; $display("FAIL lock_addr_c%0d: got %h want 100", c, s_addr); end
            n_checks++; if (m_addr_ok !== 2'b00) begin n_errors++; $display("FAIL lock_addr_ok_c%0d: got %b want 00", c, m_addr_ok); end
            @(negedge clk);
        end
        s_addr_ok = 1'b1;
        #1;
        n_checks++; if (m_addr_ok !== 2'b10) begin n_errors++; $display("FAIL lock_accept_ch1: got %b want 10", m_addr_ok); end
        n_checks++; if (s_addr !== 32'h100) begin n_errors++; $display("FAIL lock_accept_addr: got %h want 100", s_addr); end
        @(negedge clk);
        m_req = 2'b01;
        #1;
        n_checks++; if (m_addr_ok !== 2'b01) begin n_errors++; $display("FAIL lock_next_ch0: got %b want 01", m_addr_ok); end
        n_checks++; if (s_addr !== 32'h200) begin n_errors++; $display("FAIL lock_next_addr: got %h want 200", s_addr); end
        @(negedge clk);
        clear_inputs();
    endtask

    task automatic test_ordering();
        apply_reset();
        m_req = 2'b01; m_addr[31:0] = 32'h10; s_addr_ok = 1'b1;
        #1;
        n_checks++; if (m_addr_ok !== 2'b01) begin n_errors++; $display("FAIL order_acc0: got %b want 01", m_addr_ok); end
        @(negedge clk);
        m_req = 2'b10; m_addr[63:32] = 32'h20;
        #1;
        n_checks++; if (m_addr_ok !== 2'b10) begin n_errors++; $display("FAIL order_acc1: got %b want 10", m_addr_ok); end
        @(negedge clk);
        m_req = 2'b00; s_addr_ok = 1'b0; s_data_ok = 1'b1; s_rdata = 32'hAAAA0000;
        #1;
        n_checks++; if (m_data_ok !== 2'b01) begin n_errors++; $display("FAIL order_rsp0: got %b want 01", m_data_ok); end
        n_checks++; if (m_rdata !== 32'hAAAA0000) begin n_errors++; $display("FAIL order_data0: got %h want AAAA0000", m_rdata); end
        @(negedge clk);
        s_rdata = 32'h5555FFFF;
        #1;
        n_checks++; if (m_data_ok !== 2'b10) begin n_errors++; $display("FAIL order_rsp1: got %b want 10", m_data_ok); end
        n_checks++; if (m_rdata !== 32'h5555FFFF) begin n_errors++; $display("FAIL order_data1: got %h want 5555FFFF", m_rdata); end
        @(negedge clk);
        s_data_ok = 1'b0;
        #1;
        n_checks++; if (outs_cnt !== 3'd0) begin n_errors++; $display("FAIL order_drain: got %0d want 0", outs_cnt); end
        clear_inputs();
    endtask

    task automatic test_full_push_pop();
        apply_reset();
        m_req = 2'b01; s_addr_ok = 1'b1;
        repeat (4) @(negedge clk);
        s_data_ok = 1'b1;
        #1;
        n_checks++; if (s_req !== 1'b0) begin n_errors++; $display("FAIL full_no_bypass: got %b want 0", s_req); end
        n_checks++; if (m_data_ok !== 2'b01) begin n_errors++; $display("FAIL full_pop: got %b want 01", m_data_ok); end
        @(negedge clk);
        s_data_ok = 1'b0;
        #1;
        n_checks++; if (outs_cnt !== 3'd3) begin n_errors++; $display("FAIL full_after_pop: got %0d want 3", outs_cnt); end
        n_checks++; if (m_addr_ok !== 2'b01) begin n_errors++; $display("FAIL full_reissue: got %b want 01", m_addr_ok); end
        @(negedge clk);
        m_req = 2'b00; s_addr_ok = 1'b0;
        #1;
        n_checks++; if (outs_cnt !== 3'd4) begin n_errors++; $display("FAIL full_refill: got %0d want 4", outs_cnt); end
        clear_inputs();
    endtask

    task automatic test_fixed_prio();
        apply_reset();
        for (int i = 0; i < FN; i++) fp_addr[i*AW +: AW] = 32'h1000 * (i + 1);
        fp_req = 4'b1110; fp_s_addr_ok = 1'b1; fp_s_data_ok = 1'b1;
        for (int c = 0; c < 4; c++) begin
            #1;
            n_checks++; if (fp_addr_ok !== 4'b0010) begin n_errors++; $display("FAIL fp_ch1[%0d]: got %b want 0010", c, fp_addr_ok); end
            n_checks++; if (fp_s_addr !== 32'h2000) begin n_errors++; $display("FAIL fp_addr[%0d]: got %h want 2000", c, fp_s_addr); end
            @(negedge clk);
        end
        fp_req = 4'b1100;
        #1;
        n_checks++; if (fp_addr_ok !== 4'b0100) begin n_errors++; $display("FAIL fp_ch2: got %b want 0100", fp_addr_ok); end
        @(negedge clk);
        fp_req = 4'b1000;
        #1;
        n_checks++; if (fp_addr_ok !== 4'b1000) begin n_errors++; $display("FAIL fp_ch3: got %b want 1000", fp_addr_ok); end
        @(negedge clk);
        clear_inputs();
    endtask

    task automatic test_error_reset();
        apply_reset();
        s_data_ok = 1'b1;
        #1;
        n_checks++; if (m_data_ok !== 2'b00) begin n_errors++; $display("FAIL err_no_rsp: got %b want 00", m_data_ok); end
        @(negedge clk);
        s_data_ok = 1'b0;
        #1;
        n_checks++; if (err_unexp !== 1'b1) begin n_errors++; $display("FAIL err_set: got %b want 1", err_unexp); end
        m_req = 2'b01; s_addr_ok = 1'b1;
        repeat (2) @(negedge clk);
        m_req = 2'b00; s_addr_ok = 1'b0;
        #1;
        n_checks++; if (outs_cnt !== 3'd2) begin n_errors++; $display("FAIL err_burst_cnt: got %0d want 2", outs_cnt); end
        #2 resetn = 1'b0;
        #1;
        n_checks++; if (outs_cnt !== 3'd0) begin n_errors++; $display("FAIL err_async_cnt: got %0d want 0", outs_cnt); end
        n_checks++; if (err_unexp !== 1'b0) begin n_errors++; $display("FAIL err_async_clr: got %b want 0", err_unexp); end
        @(negedge clk);
        resetn = 1'b1; s_data_ok = 1'b1;
        #1;
        n_checks++; if (m_data_ok !== 2'b00) begin n_errors++; $display("FAIL err_discard: got %b want 00", m_data_ok); end
        @(negedge clk);
        s_data_ok = 1'b0;
        #1;
        n_checks++; if (err_unexp !== 1'b1) begin n_errors++; $display("FAIL err_after_reset: got %b want 1", err_unexp); end
        clear_inputs();
    endtask

    // Model: queue of owners in acceptance order, a held channel while a
    // presented request waits, and the next-preferred channel for rotation.
    task automatic test_random(input int ncyc);
        int           q[$];
        int           lock, rr, g, ch, acc;
        bit           full, gv, sreq, hs, pop;
        logic [N-1:0] exp_aok, exp_dok;
        logic [70:0]  exp_bus, got_bus;
        apply_reset();
        lock = -1; rr = 0;
        for (int c = 0; c < ncyc; c++) begin
            for (int i = 0; i < N; i++) begin
                if (!m_req[i] && $urandom_range(2) == 0) begin
                    m_req[i]            = 1'b1;
                    m_wr[i]             = 1'($urandom);
                    m_size[2*i +: 2]    = 2'($urandom);
                    m_wstrb[SW*i +: SW] = 4'($urandom);
                    m_addr[AW*i +: AW]  = $urandom;
                    m_wdata[DW*i +: DW] = $urandom;
                end
            end
            s_addr_ok = ($urandom_range(3) != 0);
            s_data_ok = (q.size() > 0) && ($urandom_range(2) == 0);
            s_rdata   = $urandom;
            full = (q.size() == D);
            if (lock >= 0) g = lock;
            else begin
                g = -1;
                for (int k = 0; k < N; k++) begin
                    ch = (rr + k) % N;
                    if (g < 0 && m_req[ch]) g = ch;
                end
            end
            gv   = !full && (g >= 0);
            sreq = gv && m_req[g];
            hs   = sreq && s_addr_ok;
            pop  = s_data_ok && (q.size() > 0);
            exp_bus = sreq ? {m_wr[g], m_size[2*g +: 2], m_wstrb[SW*g +: SW], m_addr[AW*g +: AW], m_wdata[DW*g +: DW]} : '0;
            exp_aok = hs ? (N'(1) << g) : '0;
            exp_dok = pop ? (N'(1) << q[0]) : '0;
            #1;
            got_bus = {s_wr, s_size, s_wstrb, s_addr, s_wdata};
            n_checks++; if (s_req !== sreq) begin n_errors++; $display("FAIL rnd_s_req[%0d]: got %b want %b", c, s_req, sreq); end
            n_checks++; if (got_bus !== exp_bus) begin n_errors++; $display("FAIL rnd_bus[%0d]: got %h want %h", c, got_bus, exp_bus); end
            n_checks++; if (m_addr_ok !== exp_aok) begin n_errors++; $display("FAIL rnd_addr_ok[%0d]: got %b want %b", c, m_addr_ok, exp_aok); end
            n_checks++; if (m_data_ok !== exp_dok) begin n_errors++; $display("FAIL rnd_data_ok[%0d]: got %b want %b", c, m_data_ok, exp_dok); end
            n_checks++; if (int'(outs_cnt) !== q.size()) begin n_errors++; $display("FAIL rnd_cnt[%0d]: got %0d want %0d", c, outs_cnt, q.size()); end
            n_checks++; if (err_unexp !== 1'b0) begin n_errors++; $display("FAIL rnd_err[%0d]: got %b want 0", c, err_unexp); end
            if (pop) n_checks++;
            if (pop && m_rdata !== s_rdata) begin n_errors++; $display("FAIL rnd_rdata[%0d]: got %h want %h", c, m_rdata, s_rdata); end
            if (pop) void'(q.pop_front());
            acc = -1;
            if (hs) begin
                q.push_back(g);
                rr  = (g + 1) % N;
                acc = g;
            end
            if (sreq && !s_addr_ok) lock = g;
            else if (hs) lock = -1;
            @(negedge clk);
            if (acc >= 0) m_req[acc] = 1'b0;
        end
        clear_inputs();
    endtask

    initial begin
        resetn = 1'b0;
        clear_inputs();
        test_reset();
        test_contention();
        test_lock();
        test_ordering();
        test_full_push_pop();
        test_fixed_prio();
        test_error_reset();
        test_random(400);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at %0t, limit 200000", $time);
        $fatal(1, "watchdog expired");
    end

endmodule
